// File: rtl/pipelined_barrel_shifter.sv
// Pipelined barrel shifter: one register per power-of-two shift stage (SRL/SLL/SRA/ROR).
// Valid/ready handshake with full backpressure; empty stages refill while later ones stall.
module pipelined_barrel_shifter #(
  parameter  int WIDTH = 32,
  parameter  int TAG_W = 5,
  localparam int SHW   = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic [SHW-1:0]   in_amt,
  input  logic [1:0]       in_mode,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic [TAG_W-1:0] out_tag,
  output logic             busy
);

  typedef enum logic [1:0] {
    MODE_SRL = 2'b00,
    MODE_SLL = 2'b01,
    MODE_SRA = 2'b10,
    MODE_ROR = 2'b11
  } mode_e;

  function automatic logic [WIDTH-1:0] shift_by(
    input logic [WIDTH-1:0] d,
    input logic [1:0]       mode,
    input logic             sign,
    input int               s
  );
    logic [WIDTH-1:0] ones;
    logic [WIDTH-1:0] res;
    ones = '1;
    case (mode)
      MODE_SRL: res = d >> s;
      MODE_SLL: res = d << s;
      MODE_SRA: res = sign ? ((d >> s) | ~(ones >> s)) : (d >> s);
      default:  res = (d >> s) | (d << (WIDTH - s));
    endcase
    return res;
  endfunction

  logic [SHW-1:0]   valid_all;
  logic [SHW-1:0]   adv;
  logic [WIDTH-1:0] stg_data [SHW];
  logic [SHW-1:0]   stg_amt  [SHW];
  logic [1:0]       stg_mode [SHW];
  logic             stg_sign [SHW];
  logic [TAG_W-1:0] stg_tag  [SHW];

  for (genvar k = 0; k < SHW; k++) begin : g_stage
    logic             v_in;
    logic [WIDTH-1:0] d_in;
    logic [SHW-1:0]   amt_in;
    logic [1:0]       mode_in;
    logic             sign_in;
    logic [TAG_W-1:0] tag_in;
    logic [WIDTH-1:0] data_d;

    logic             valid_q;
    logic [WIDTH-1:0] data_q;
    logic [SHW-1:0]   amt_q;
    logic [1:0]       mode_q;
    logic             sign_q;
    logic [TAG_W-1:0] tag_q;

    if (k == 0) begin : g_head
      // Sign is captured from the untouched operand so SRA fill survives earlier stages.
      assign v_in    = in_valid;
      assign d_in    = in_data;
      assign amt_in  = in_amt;
      assign mode_in = in_mode;
      assign sign_in = in_data[WIDTH-1];
      assign tag_in  = in_tag;
    end else begin : g_body
      assign v_in    = valid_all[k-1];
      assign d_in    = stg_data[k-1];
      assign amt_in  = stg_amt[k-1];
      assign mode_in = stg_mode[k-1];
      assign sign_in = stg_sign[k-1];
      assign tag_in  = stg_tag[k-1];
    end

    // Stage k moves when any stage from k to the tail has a hole, or the sink takes the result.
    assign adv[k]  = out_ready | ~(&valid_all[SHW-1:k]);
    assign data_d  = amt_in[k] ? shift_by(d_in, mode_in, sign_in, 1 << k) : d_in;

    always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
        valid_q <= 1'b0;
        data_q  <= '0;
        amt_q   <= '0;
        mode_q  <= '0;
        sign_q  <= 1'b0;
        tag_q   <= '0;
      end else if (adv[k]) begin
        valid_q <= v_in;
        data_q  <= data_d;
        amt_q   <= amt_in;
        mode_q  <= mode_in;
        sign_q  <= sign_in;
        tag_q   <= tag_in;
      end
    end

    assign valid_all[k] = valid_q;
    assign stg_data[k]  = data_q;
    assign stg_amt[k]   = amt_q;
    assign stg_mode[k]  = mode_q;
    assign stg_sign[k]  = sign_q;
    assign stg_tag[k]   = tag_q;
  end

  assign in_ready  = adv[0];
  assign out_valid = valid_all[SHW-1];
  assign out_data  = stg_data[SHW-1];
  assign out_tag   = stg_tag[SHW-1];
  assign busy      = |valid_all;

endmodule

// File: tb/tb_pipelined_barrel_shifter.sv
// Self-checking bench for pipelined_barrel_shifter (WIDTH=32): vector table plus
// scoreboard-tracked backpressure, bubble, mid-flight reset and random-stall sequences.
module tb_pipelined_barrel_shifter;
  localparam int WIDTH = 32;
  localparam int SHW   = 5;
  localparam int TAG_W = 5;

  logic             clk = 1'b0;
  logic             rst;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_data;
  logic [SHW-1:0]   in_amt;
  logic [1:0]       in_mode;
  logic [TAG_W-1:0] in_tag;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_data;
  logic [TAG_W-1:0] out_tag;
  logic             busy;

  always #5 clk = ~clk;

  pipelined_barrel_shifter #(.WIDTH(WIDTH), .TAG_W(TAG_W)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_amt    (in_amt),
    .in_mode   (in_mode),
    .in_tag    (in_tag),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_tag   (out_tag),
    .busy      (busy)
  );

  typedef struct {
    logic [31:0] data;
    logic [4:0]  amt;
    logic [1:0]  mode;
    logic [4:0]  tag;
    logic [31:0] exp;
  } vec_t;

  typedef struct {
    logic [31:0] data;
    logic [4:0]  tag;
    int          cyc;
    bit          lat;
  } sb_t;

  sb_t         sb_q[$];
  sb_t         sb_e;
  vec_t        vt[12];
  int          n_cmp = 0;
  int          n_err = 0;
  int          cyc   = 0;
  int          n_acc = 0;
  bit          lat_en = 1'b0;
  bit          rnd_done;
  logic [31:0] drv_exp;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge rst) sb_q.delete();

  // Scoreboard: sampled on the falling edge, describing what the next rising edge does.
  always @(negedge clk) begin
    if (rst === 1'b1) begin
      if (in_valid && in_ready) begin
        sb_q.push_back('{drv_exp, in_tag, cyc, lat_en});
        n_acc++;
      end
      if (out_valid && out_ready) begin
        n_cmp++;
        if (sb_q.size() == 0) begin
          n_err++;
          $display("FAIL sb_unexpected: got tag %0d data %h, required no result", out_tag, out_data);
        end else begin
          sb_e = sb_q.pop_front();
          if (out_data !== sb_e.data || out_tag !== sb_e.tag) begin
            n_err++;
            $display("FAIL sb_result: got tag %0d data %h, required tag %0d data %h",
                     out_tag, out_data, sb_e.tag, sb_e.data);
          end
          if (sb_e.lat) begin
            n_cmp++;
            if (cyc - sb_e.cyc != SHW) begin
              n_err++;
              $display("FAIL latency tag %0d: got %0d cycles, required %0d", sb_e.tag, cyc - sb_e.cyc, SHW);
            end
          end
        end
      end
    end
  end

  function automatic logic [31:0] ref_sh(input logic [31:0] d, input logic [4:0] a, input logic [1:0] m);
    case (m)
      2'b00:   return d >> a;
      2'b01:   return d << a;
      2'b10:   return $unsigned($signed(d) >>> a);
      default: return (d >> a) | (d << (32 - int'(a)));
    endcase
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, required %h", name, act, exp);
    end
  endtask

  // Called at posedge+1; returns at posedge+1 after the accepting edge.
  task automatic drive(input logic [31:0] d, input logic [4:0] a, input logic [1:0] m,
                       input logic [4:0] t, input logic [31:0] e);
    bit ok;
    ok = 1'b0;
    in_valid = 1'b1; in_data = d; in_amt = a; in_mode = m; in_tag = t; drv_exp = e;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (in_ready) begin
        ok = 1'b1;
        break;
      end
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
    if (!ok) begin
      n_cmp++; n_err++;
      $display("FAIL drive_timeout tag %0d: got in_ready 0, required 1 within 200 cycles", t);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic drain(input string name);
    bit done;
    done = 1'b0;
    for (int i = 0; i < 100; i++) begin
      if (sb_q.size() == 0 && !busy) begin
        done = 1'b1;
        break;
      end
      @(posedge clk); #1;
    end
    check(name, done, 1);
  endtask

  task automatic wait_out_valid(input string name);
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      if (out_valid) begin
        seen = 1'b1;
        break;
      end
    end
    @(posedge clk); #1;
    check(name, seen, 1);
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: got no finish, required finish before 300us");
    $fatal(1);
  end

  initial begin
    logic [31:0] hd;
    logic [4:0]  ht;
    bit          held;
    int          base;
    int          cnt;
    int          c0;

    vt[0]  = '{32'h8000_00F1, 5'd4,  2'b00, 5'd1,  32'h0800_000F};
    vt[1]  = '{32'h8000_00F1, 5'd4,  2'b01, 5'd2,  32'h0000_0F10};
    vt[2]  = '{32'h8000_00F1, 5'd4,  2'b10, 5'd3,  32'hF800_000F};
    vt[3]  = '{32'h8000_00F1, 5'd4,  2'b11, 5'd4,  32'h1800_000F};
    vt[4]  = '{32'hDEAD_BEEF, 5'd0,  2'b00, 5'd5,  32'hDEAD_BEEF};
    vt[5]  = '{32'hDEAD_BEEF, 5'd0,  2'b01, 5'd6,  32'hDEAD_BEEF};
    vt[6]  = '{32'hDEAD_BEEF, 5'd0,  2'b10, 5'd7,  32'hDEAD_BEEF};
    vt[7]  = '{32'hDEAD_BEEF, 5'd0,  2'b11, 5'd8,  32'hDEAD_BEEF};
    vt[8]  = '{32'h8000_0000, 5'd31, 2'b10, 5'd9,  32'hFFFF_FFFF};
    vt[9]  = '{32'h0000_0001, 5'd31, 2'b01, 5'd10, 32'h8000_0000};
    vt[10] = '{32'h8000_0000, 5'd31, 2'b00, 5'd11, 32'h0000_0001};
    vt[11] = '{32'h0000_0001, 5'd31, 2'b11, 5'd12, 32'h0000_0002};

    rst = 1'b0; in_valid = 1'b0; in_data = '0; in_amt = '0; in_mode = '0; in_tag = '0;
    out_ready = 1'b1; drv_exp = '0;

    // Reset and idle
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_out_valid", out_valid, 0);
    check("rst_busy", busy, 0);
    check("rst_in_ready", in_ready, 1);
    check("rst_out_data", out_data, 0);
    check("rst_out_tag", out_tag, 0);
    rst = 1'b1;
    idle(2);
    check("idle_out_valid", out_valid, 0);
    check("idle_busy", busy, 0);
    check("idle_in_ready", in_ready, 1);
    check("idle_out_data", out_data, 0);

    // Vector table, issued back to back with latency checking
    lat_en = 1'b1;
    for (int i = 0; i < 12; i++)
      drive(vt[i].data, vt[i].amt, vt[i].mode, vt[i].tag, vt[i].exp);
    lat_en = 1'b0;
    drain("table_drain");

    // Back-to-back with backpressure
    out_ready = 1'b0;
    base = n_acc;
    held = 1'b0; hd = '0; ht = '0;
    fork
      begin
        for (int i = 0; i < 8; i++) begin
          logic [31:0] d;
          logic [4:0]  a;
          logic [1:0]  m;
          d = $urandom; a = 5'($urandom_range(0, 31)); m = 2'($urandom_range(0, 3));
          drive(d, a, m, 5'(i), ref_sh(d, a, m));
        end
      end
      begin
        for (int c = 0; c < 10; c++) begin
          @(negedge clk);
          if (out_valid) begin
            if (!held) begin
              held = 1'b1; hd = out_data; ht = out_tag;
            end else begin
              check("stall_hold", {27'd0, out_tag, out_data}, {27'd0, ht, hd});
            end
          end
        end
        check("stall_seen_output", held, 1);
        check("stall_in_ready", in_ready, 0);
        check("stall_accepted", n_acc - base, 5);
        check("stall_busy", busy, 1);
        @(posedge clk); #1;
        out_ready = 1'b1;
        cnt = 0;
        for (int c = 0; c < 8; c++) begin
          @(negedge clk);
          if (out_valid) cnt++;
        end
        check("stream_one_per_cycle", cnt, 8);
      end
    join
    idle(1);
    drain("bp_drain");

    // Bubble collapse
    out_ready = 1'b0;
    drive(32'h0000_F000, 5'd8, 2'b00, 5'd20, 32'h0000_00F0);
    wait_out_valid("bubble_first_at_output");
    idle(2);
    base = n_acc;
    c0 = cyc;
    drive(32'h0000_000F, 5'd3, 2'b01, 5'd21, 32'h0000_0078);
    check("bubble_accept_cycles", cyc - c0, 1);
    check("bubble_accepted", n_acc - base, 1);
    idle(3);
    check("bubble_first_held", {out_valid, out_tag}, {1'b1, 5'd20});
    out_ready = 1'b1;
    drain("bubble_drain");

    // Reset while transactions are in flight
    out_ready = 1'b0;
    drive(32'h1234_5678, 5'd1, 2'b00, 5'd9,  32'h091A_2B3C);
    drive(32'h1234_5678, 5'd2, 2'b01, 5'd10, 32'h48D1_59E0);
    drive(32'h1234_5678, 5'd3, 2'b11, 5'd11, 32'h0246_8ACF);
    wait_out_valid("midrst_output_present");
    #2 rst = 1'b0;
    #1;
    check("midrst_out_valid", out_valid, 0);
    check("midrst_busy", busy, 0);
    check("midrst_out_data", out_data, 0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b1;
    cnt = 0;
    for (int c = 0; c < 12; c++) begin
      @(negedge clk);
      if (out_valid) cnt++;
    end
    check("midrst_no_stale", cnt, 0);
    check("midrst_in_ready", in_ready, 1);
    @(posedge clk); #1;

    // Random traffic under random output stalls
    rnd_done = 1'b0;
    fork
      begin
        for (int i = 0; i < 40; i++) begin
          logic [31:0] d;
          logic [4:0]  a;
          logic [1:0]  m;
          d = $urandom; a = 5'($urandom_range(0, 31)); m = 2'($urandom_range(0, 3));
          drive(d, a, m, 5'(i), ref_sh(d, a, m));
          if ($urandom_range(0, 3) == 0) idle(1);
        end
        rnd_done = 1'b1;
      end
      begin
        for (int c = 0; c < 2000 && !rnd_done; c++) begin
          @(posedge clk); #1;
          out_ready = ($urandom_range(0, 3) != 0);
        end
      end
    join
    out_ready = 1'b1;
    drain("random_drain");

    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
    $finish;
  end

endmodule
